// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared control encodings for the fetch path.
//   - NPCOp encodings driven by EX when it resolves a control transfer
//   - default NOP instruction word (addi x0,x0,0)
//   - fetch FSM state encoding and the IF/ID / skid-buffer record types
package fetch_unit_pkg;

  localparam logic [2:0]  NPC_NONE = 3'b000;
  localparam logic [2:0]  NPC_BR   = 3'b001;
  localparam logic [2:0]  NPC_JAL  = 3'b010;
  localparam logic [2:0]  NPC_JALR = 3'b100;

  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // request outstanding at PC
    ST_HOLD  = 2'd1,  // no request; one instruction parked in the buffer
    ST_DROP  = 2'd2   // stale request in flight; its response will be discarded
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } ifid_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fbuf_t;

  // Only the three defined encodings redirect; anything else is ignored.
  function automatic logic is_redirect(input logic [2:0] op);
    return (op == NPC_BR) || (op == NPC_JAL) || (op == NPC_JALR);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus.
//   req   fetch side -> memory : request valid
//   addr  fetch side -> memory : fetch address, stable until ready
//   ready memory -> fetch side : response valid this cycle
//   rdata memory -> fetch side : instruction word
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch_unit_npc_target.sv
// npc_target: combinational redirect decode and target computation.
//   op     in  NPCOp from EX
//   pc     in  PC of the redirecting instruction
//   imm    in  branch/jal offset
//   alu    in  jalr target from the ALU
//   redir  out redirect active
//   target out next PC (mod 2^32)
module npc_target
  import fetch_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] alu,
  output logic        redir,
  output logic [31:0] target
);

  // jalr clears bit 0 of the computed address, so alu[0] is never used.
  logic unused_alu0;
  assign unused_alu0 = alu[0];

  assign redir  = is_redirect(op);
  assign target = (op == NPC_JALR) ? {alu[31:1], 1'b0} : (pc + imm);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with a one-entry skid
// buffer and redirect handling.
//   clk, rst          clock, async active-high reset
//   stall             ID hazard: IF/ID must not advance
//   redir_*           resolved control transfer from EX
//   imem (master)     instruction memory bus
//   PC_out/inst_out/valid_out  IF/ID register
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic [2:0]         redir_NPCOp,
  input  logic [31:0]        redir_PC,
  input  logic [31:0]        redir_immout,
  input  logic [31:0]        redir_aluout,
  fetch_unit_if.master       imem,
  output logic [31:0]        PC_out,
  output logic [31:0]        inst_out,
  output logic               valid_out
);

  localparam ifid_t IFID_FLUSH = '{pc: 32'h0, inst: NOP_INST, valid: 1'b0};

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tgt_q, tgt_d;
  fbuf_t        buf_q, buf_d;
  ifid_t        ifid_q, ifid_d;

  logic         redir;
  logic [31:0]  target;

  npc_target u_npc_target (
    .op     (redir_NPCOp),
    .pc     (redir_PC),
    .imm    (redir_immout),
    .alu    (redir_aluout),
    .redir  (redir),
    .target (target)
  );

  // In DROP pc_q still holds the stale address, so addr stays stable until
  // the abandoned response arrives.
  assign imem.req  = (state_q != ST_HOLD);
  assign imem.addr = pc_q;

  assign PC_out    = ifid_q.pc;
  assign inst_out  = ifid_q.inst;
  assign valid_out = ifid_q.valid;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    buf_d   = buf_q;
    ifid_d  = ifid_q;
    unique case (state_q)
      ST_FETCH: begin
        if (redir) begin
          ifid_d = IFID_FLUSH;
          if (imem.ready) begin
            pc_d = target;
          end else begin
            tgt_d   = target;
            state_d = ST_DROP;
          end
        end else if (imem.ready) begin
          pc_d = pc_q + 32'd4;
          if (!stall) begin
            ifid_d = '{pc: pc_q, inst: imem.rdata, valid: 1'b1};
          end else begin
            buf_d   = '{pc: pc_q, inst: imem.rdata};
            state_d = ST_HOLD;
          end
        end else if (!stall) begin
          ifid_d = IFID_FLUSH;  // bubble while waiting on memory
        end
      end
      ST_HOLD: begin
        if (redir) begin
          ifid_d  = IFID_FLUSH;
          buf_d   = '0;
          pc_d    = target;
          state_d = ST_FETCH;
        end else if (!stall) begin
          ifid_d  = '{pc: buf_q.pc, inst: buf_q.inst, valid: 1'b1};
          state_d = ST_FETCH;
        end
      end
      ST_DROP: begin
        ifid_d = IFID_FLUSH;
        if (redir) tgt_d = target;  // newest redirect wins
        if (imem.ready) begin
          pc_d    = redir ? target : tgt_q;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      buf_q   <= '0;
      ifid_q  <= IFID_FLUSH;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      buf_q   <= buf_d;
      ifid_q  <= ifid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a scoreboard of instructions expected
// to be consumed by ID, plus direct checks on the memory bus and IF/ID.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk, rst, stall;
  logic [2:0]  op;
  logic [31:0] rpc, imm, alu;
  logic        mem_rdy;
  logic [31:0] PC_out, inst_out;
  logic        valid_out;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];

  fetch_unit_if imem();

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'hAB00_0000 | {8'h00, a[23:0]};
  endfunction

  assign imem.ready = mem_rdy;
  assign imem.rdata = inst_of(imem.addr);

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redir_NPCOp  (op),
    .redir_PC     (rpc),
    .redir_immout (imm),
    .redir_aluout (alu),
    .imem         (imem),
    .PC_out       (PC_out),
    .inst_out     (inst_out),
    .valid_out    (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    sb.push_back('{pc: a, inst: inst_of(a)});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ID consumes IF/ID on an edge where it is valid, not stalled and not
  // being killed by a same-cycle redirect.
  always @(negedge clk) begin
    if (!rst && valid_out && !stall && !(op == 3'b001 || op == 3'b010 || op == 3'b100)) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_extra: got pc=%h inst=%h expected none", PC_out, inst_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (PC_out !== e.pc || inst_out !== e.inst) begin
          fails++;
          $display("FAIL sb_ifid: got pc=%h inst=%h expected pc=%h inst=%h",
                   PC_out, inst_out, e.pc, e.inst);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; op = 3'b000; rpc = '0; imm = '0; alu = '0; mem_rdy = 1'b0;
    #2;
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_pc", PC_out, 32'd0);
    chk("rst_inst", inst_out, NOP);
    chk("rst_req", {31'd0, imem.req}, 32'd1);
    chk("rst_addr", imem.addr, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // streaming fetch
    mem_rdy = 1'b1; push(32'h0); #1 chk("s_addr0", imem.addr, 32'h0);
    cyc(); push(32'h4); #1;
    chk("s_valid", {31'd0, valid_out}, 32'd1);
    chk("s_pc0", PC_out, 32'h0);
    chk("s_addr4", imem.addr, 32'h4);

    // stall on ready at 0x8 -> HOLD for 3 stall cycles
    cyc(); stall = 1'b1; push(32'h8); #1 chk("h_addr8", imem.addr, 32'h8);
    cyc(); mem_rdy = 1'b0; #1;
    chk("h_req0", {31'd0, imem.req}, 32'd0);
    chk("h_pc_held", PC_out, 32'h4);
    cyc(); #1 chk("h_req0b", {31'd0, imem.req}, 32'd0);
    chk("h_pc_held2", PC_out, 32'h4);
    cyc(); stall = 1'b0; #1 chk("h_req0c", {31'd0, imem.req}, 32'd0);
    cyc(); mem_rdy = 1'b1; #1;
    chk("h_pc8", PC_out, 32'h8);
    chk("h_addrC", imem.addr, 32'hC);

    // branch redirect with ready (0xC in IF/ID is killed)
    cyc(); op = 3'b001; rpc = 32'h10; imm = 32'h20; #1 chk("b_addr10", imem.addr, 32'h10);
    cyc(); op = 3'b000; push(32'h30); #1;
    chk("b_flush_valid", {31'd0, valid_out}, 32'd0);
    chk("b_flush_pc", PC_out, 32'd0);
    chk("b_flush_inst", inst_out, NOP);
    chk("b_addr30", imem.addr, 32'h30);
    cyc(); push(32'h34); #1 chk("b_addr34", imem.addr, 32'h34);
    cyc(); push(32'h38); #1 chk("b_addr38", imem.addr, 32'h38);
    cyc(); #1 chk("b_addr3C", imem.addr, 32'h3C);

    // jalr redirect while the request at 0x40 is pending
    cyc(); mem_rdy = 1'b0; op = 3'b100; alu = 32'h101; #1 chk("j_addr40", imem.addr, 32'h40);
    cyc(); op = 3'b000; #1;
    chk("j_drop_addr", imem.addr, 32'h40);
    chk("j_drop_req", {31'd0, imem.req}, 32'd1);
    chk("j_drop_valid", {31'd0, valid_out}, 32'd0);
    cyc(); mem_rdy = 1'b1; #1 chk("j_drop_addr2", imem.addr, 32'h40);

    // redirect during DROP: newest target wins
    cyc(); mem_rdy = 1'b0; op = 3'b100; alu = 32'h201; #1;
    chk("j_addr100", imem.addr, 32'h100);
    chk("j_valid0", {31'd0, valid_out}, 32'd0);
    cyc(); op = 3'b010; rpc = 32'h0; imm = 32'h80; #1 chk("d_addr100", imem.addr, 32'h100);
    cyc(); op = 3'b000; mem_rdy = 1'b1; #1 chk("d_addr100b", imem.addr, 32'h100);
    cyc(); push(32'h80); #1 chk("d_addr80", imem.addr, 32'h80);

    // not-ready without stall -> bubble
    cyc(); mem_rdy = 1'b0; #1;
    chk("n_pc80", PC_out, 32'h80);
    chk("n_addr84", imem.addr, 32'h84);
    cyc(); mem_rdy = 1'b1; push(32'h84); #1;
    chk("n_bubble", {31'd0, valid_out}, 32'd0);
    chk("n_addr84b", imem.addr, 32'h84);
    cyc(); mem_rdy = 1'b0; #1;
    chk("n_pc84", PC_out, 32'h84);
    chk("n_addr88", imem.addr, 32'h88);

    // enter HOLD with stall, then reset mid-cycle
    cyc(); mem_rdy = 1'b1; stall = 1'b1; #1 chk("r_addr88", imem.addr, 32'h88);
    cyc(); mem_rdy = 1'b0; #1 chk("r_hold_req", {31'd0, imem.req}, 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("r_valid", {31'd0, valid_out}, 32'd0);
    chk("r_pc", PC_out, 32'd0);
    chk("r_inst", inst_out, NOP);
    chk("r_req", {31'd0, imem.req}, 32'd1);
    chk("r_addr", imem.addr, 32'd0);
    @(posedge clk); #1 rst = 1'b0; stall = 1'b0;
    mem_rdy = 1'b1; push(32'h0); #1 chk("r_addr0", imem.addr, 32'h0);
    cyc(); push(32'h4); #1;
    chk("r_pc0", PC_out, 32'h0);
    chk("r_addr4", imem.addr, 32'h4);
    cyc(); mem_rdy = 1'b0;
    cyc();
    cyc();
    chk("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, is the instruction word presented when the output is invalid.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 stall  in  1  hazard hold; IF/ID output must not advance.
REQ-006 redir_NPCOp  in  3  resolved next-PC op from EX (000 none, 001 branch taken, 010 jal, 100 jalr).
REQ-007 redir_PC  in  32  PC of the redirecting instruction.
REQ-008 redir_immout  in  32  branch/jal offset.
REQ-009 redir_aluout  in  32  jalr target.
REQ-010 imem_req  out  1  instruction-memory request.
REQ-011 imem_addr  out  32  fetch address; held stable while imem_req=1 and imem_ready=0.
REQ-012 imem_ready  in  1  response valid this cycle; may arrive in the request cycle or later.
REQ-013 imem_rdata  in  32  instruction word, valid when imem_ready=1.
REQ-014 PC_out  out  32  registered IF/ID PC.
REQ-015 inst_out  out  32  registered IF/ID instruction.
REQ-016 valid_out  out  1  IF/ID slot holds a real instruction.

Function
REQ-017 Redirect SHALL be active when redir_NPCOp is 001, 010 or 100; every other encoding is no redirect.
REQ-018 Target SHALL be redir_PC+redir_immout for 001/010 and {redir_aluout[31:1],1'b0} for 100; all adds wrap mod 2^32.
REQ-019 States SHALL be FETCH, HOLD and DROP.
REQ-020 FETCH drives imem_req=1 and imem_addr=PC; HOLD drives imem_req=0; DROP drives imem_req=1 and imem_addr=the old PC.
REQ-021 FETCH, no redirect, ready, !stall: IF/ID <= {PC, rdata, valid=1}; PC <= PC+4.
REQ-022 FETCH, no redirect, ready, stall: buffer <= {PC, rdata}; PC <= PC+4; IF/ID held; go to HOLD.
REQ-023 FETCH, no redirect, !ready: if !stall, IF/ID becomes a bubble; if stall, IF/ID is held.
REQ-024 HOLD, no redirect: if !stall, IF/ID <= {buffer, valid=1} and go to FETCH; otherwise stay in HOLD.
REQ-025 Redirect SHALL have priority over stall and SHALL flush IF/ID to {PC_out=0, inst_out=NOP_INST, valid_out=0} on the next edge.
REQ-026 Redirect in FETCH with ready: PC <= target; response discarded; stay in FETCH.
REQ-027 Redirect in FETCH without ready: target_reg <= target; go to DROP.
REQ-028 Redirect in HOLD: buffer discarded; PC <= target; go to FETCH.
REQ-029 DROP holds IF/ID invalid; a new redirect overwrites target_reg (newest wins).
REQ-030 DROP on ready: response discarded; PC <= target_reg (or the same-cycle redirect target); go to FETCH.
REQ-031 Fetch-to-IF/ID latency SHALL be 0 cycles after imem_ready, i.e. the output is valid on the edge that ends the ready cycle.
REQ-032 There SHALL be at most one outstanding request and at most one buffered instruction.

Reset
REQ-033 rst SHALL immediately force PC=RESET_PC, state=FETCH, PC_out=0, inst_out=NOP_INST, valid_out=0, buffer and target_reg cleared.
REQ-034 Reset mid-request SHALL abandon the request; any response in the first post-reset cycle belongs to the new request at RESET_PC.

Structure
REQ-035 NPCOp encodings, NOP_INST and state encodings SHALL live in the shared control-encoding define header used by ctrl.
REQ-036 Target computation SHALL be one combinational sub-module named npc_target; the FSM, PC, buffer and IF/ID register stay in fetch_unit.

Verification
REQ-037 Reset, then imem_ready=1 every cycle, stall=0 -> imem_addr 0,4,8,...; valid_out=1 from the first edge after reset with PC_out following one cycle behind.
REQ-038 Ready at PC 0x8, stall=1 for 3 cycles -> HOLD; imem_req=0; IF/ID held; after release, PC_out=0x8, next imem_addr=0xC.
REQ-039 Redirect 001, redir_PC=0x10, imm=0x20, with ready -> valid_out=0 next cycle, then imem_addr=0x30.
REQ-040 Redirect 100, aluout=0x101, with the request pending at 0x40 and ready 2 cycles later -> addr held at 0x40, response dropped, next imem_addr=0x100.
REQ-041 Second redirect 010 (PC=0x0, imm=0x80) during DROP -> fetch resumes at 0x80.
REQ-042 rst pulsed while in HOLD with stall=1 -> outputs at reset values immediately; fetch restarts at RESET_PC.
